// File: rtl/ext_mem_pkg.sv
// Shared types and constants for the external data-memory responder.
// Holds the FSM encoding, interface widths and the index-width helper.
package ext_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W  = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  // Ceiling log2, usable in parameter context to size the word index.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/ext_mem_if.sv
// CPU-side external data-memory bus: request from the initiator,
// read data and a one-cycle ready pulse from the responder.
interface ext_mem_if;

  logic [ext_mem_pkg::ADDR_W-1:0] ext_mem_addr;
  logic [ext_mem_pkg::DATA_W-1:0] ext_mem_wdata;
  logic                           ext_mem_write;
  logic                           ext_mem_read;
  logic [ext_mem_pkg::DATA_W-1:0] ext_mem_rdata;
  logic                           ext_mem_ready;

  modport master (
    output ext_mem_addr, ext_mem_wdata, ext_mem_write, ext_mem_read,
    input  ext_mem_rdata, ext_mem_ready
  );

  modport slave (
    input  ext_mem_addr, ext_mem_wdata, ext_mem_write, ext_mem_read,
    output ext_mem_rdata, ext_mem_ready
  );

endinterface

// File: rtl/mem_word_array.sv
// Single-port synchronous word RAM; the read port is registered and only
// updates when re is asserted, so it holds the last word read.
module mem_word_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left without a reset so it maps onto RAM
  // macros; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata    <= mem[idx];
  end

endmodule

// File: rtl/ext_mem_responder.sv
// Memory-side responder: one request at a time, WAIT_CYCLES wait states,
// single-cycle ready pulse, sticky error flag and completion counters.
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  ext_mem_if.slave    bus,
  output logic        busy,
  output logic        err,
  input  logic        err_clear,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int AW = clog2(DEPTH);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                write_q, dual_q;
  logic                rd_zero;
  logic                req, sample, enter_resp, err_set;
  logic                in_range, ram_we, ram_re;
  logic [ADDR_W-1:0]   op_addr;
  logic [DATA_W-1:0]   op_wdata;
  logic                op_write, op_dual;
  logic [DATA_W-1:0]   ram_rdata;

  assign req    = bus.ext_mem_read | bus.ext_mem_write;
  assign sample = (state == IDLE) && req;

  // With zero wait states RESP is entered on the sampling edge itself, so the
  // live bus must feed the array; otherwise the latched request does.
  assign op_addr  = (state == IDLE) ? bus.ext_mem_addr  : addr_q;
  assign op_wdata = (state == IDLE) ? bus.ext_mem_wdata : wdata_q;
  assign op_write = (state == IDLE) ? bus.ext_mem_write : write_q;
  assign op_dual  = (state == IDLE) ? (bus.ext_mem_write & bus.ext_mem_read) : dual_q;

  assign in_range = (op_addr >> (AW + 2)) == '0;
  assign ram_we   = enter_resp &&  op_write && in_range;
  assign ram_re   = enter_resp && !op_write && in_range;
  assign err_set  = enter_resp && (!in_range || op_dual);

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx   = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nx   = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      dual_q   <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
      err      <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      state <= state_nx;
      if (sample) begin
        addr_q  <= bus.ext_mem_addr;
        wdata_q <= bus.ext_mem_wdata;
        write_q <= bus.ext_mem_write;
        dual_q  <= bus.ext_mem_write & bus.ext_mem_read;
        cnt     <= CNT_W'(WAIT_CYCLES);
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (enter_resp) begin
        if (op_write) begin
          wr_count <= wr_count + 16'd1;
        end else begin
          rd_count <= rd_count + 16'd1;
          rd_zero  <= !in_range;
        end
      end
      if (err_set)        err <= 1'b1;
      else if (err_clear) err <= 1'b0;
    end
  end

  mem_word_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (op_addr[AW+1:2]),
    .wdata (op_wdata),
    .rdata (ram_rdata)
  );

  // The RAM output register has no reset; rd_zero masks it after reset and
  // after an out-of-range read until the next in-range read lands.
  assign bus.ext_mem_rdata = rd_zero ? '0 : ram_rdata;
  assign bus.ext_mem_ready = (state == RESP);
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_ext_mem_responder.sv
// Self-checking bench: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 responder driven
// from a vector table with a response scoreboard, plus hand-timed sequences.
module tb_ext_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ext_mem_if b2();
  ext_mem_if b0();

  logic        busy2, err2, err_clear2;
  logic        busy0, err0, err_clear0;
  logic [15:0] rd_count2, wr_count2, rd_count0, wr_count0;

  ext_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(b2), .busy(busy2), .err(err2),
    .err_clear(err_clear2), .rd_count(rd_count2), .wr_count(wr_count2)
  );

  ext_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(b0), .busy(busy0), .err(err0),
    .err_clear(err_clear0), .rd_count(rd_count0), .wr_count(wr_count0)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_rd[3];
  int   exp_wr[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [31:0] d);
    if (sel == 0) begin
      b0.ext_mem_read = rd; b0.ext_mem_write = wr; b0.ext_mem_addr = a; b0.ext_mem_wdata = d;
    end else begin
      b2.ext_mem_read = rd; b2.ext_mem_write = wr; b2.ext_mem_addr = a; b2.ext_mem_wdata = d;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? b0.ext_mem_ready : b2.ext_mem_ready;
  endfunction
  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? b0.ext_mem_rdata : b2.ext_mem_rdata;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy0 : busy2;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? err0 : err2;
  endfunction
  function automatic logic [15:0] get_rdcnt(input int sel);
    return (sel == 0) ? rd_count0 : rd_count2;
  endfunction
  function automatic logic [15:0] get_wrcnt(input int sel);
    return (sel == 0) ? wr_count0 : wr_count2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: expectation queued at issue, compared when ready shows.
  task automatic txn(input int sel, input logic rd, input logic wr, input logic [15:0] a,
                     input logic [31:0] d, input logic [31:0] er, input logic ee,
                     input string name);
    exp_t e;
    int   n;
    e.rdata = er; e.err = ee; e.name = name;
    sb.push_back(e);
    drive(sel, rd, wr, a, d);
    n = 0;
    do begin
      tick();
      n++;
    end while (!get_ready(sel) && n < 40);
    drive(sel, 1'b0, 1'b0, 16'h0, 32'h0);
    e = sb.pop_front();
    if (!get_ready(sel)) begin
      check({e.name, "_ready_timeout"}, 32'd0, 32'd1);
    end else begin
      if (wr) exp_wr[sel]++;
      else    exp_rd[sel]++;
      check({e.name, "_rdata"}, get_rdata(sel), e.rdata);
      check({e.name, "_err"}, get_err(sel), e.err);
      check({e.name, "_rd_count"}, get_rdcnt(sel), exp_rd[sel]);
      check({e.name, "_wr_count"}, get_wrcnt(sel), exp_wr[sel]);
    end
    tick();
    check({e.name, "_rdata_hold"}, get_rdata(sel), e.rdata);
    check({e.name, "_idle"}, {get_busy(sel), get_ready(sel)}, 2'b00);
  endtask

  task automatic clear_err(input int sel);
    if (sel == 0) err_clear0 = 1'b1; else err_clear2 = 1'b1;
    tick();
    if (sel == 0) err_clear0 = 1'b0; else err_clear2 = 1'b0;
    check("err_clear", get_err(sel), 1'b0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b1, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, "rd_0010"});
    vecs.push_back('{1'b1, 1'b0, 16'h0013, 32'h0,        32'hDEADBEEF, 1'b0, "rd_0013"});
    vecs.push_back('{1'b0, 1'b1, 16'h0044, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, "wr_0044"});
    vecs.push_back('{1'b1, 1'b0, 16'h0044, 32'h0,        32'hCAFEF00D, 1'b0, "rd_0044"});
    vecs.push_back('{1'b0, 1'b1, 16'h0FFC, 32'h0BADC0DE, 32'hCAFEF00D, 1'b0, "wr_last"});
    vecs.push_back('{1'b1, 1'b0, 16'h0FFE, 32'h0,        32'h0BADC0DE, 1'b0, "rd_last"});
    vecs.push_back('{1'b0, 1'b1, 16'h0030, 32'hAAAA5555, 32'h0BADC0DE, 1'b0, "wr_0030"});
    vecs.push_back('{1'b1, 1'b0, 16'h0030, 32'h0,        32'hAAAA5555, 1'b0, "rd_0030"});
    vecs.push_back('{1'b0, 1'b1, 16'h0000, 32'h00000001, 32'hAAAA5555, 1'b0, "wr_0000"});
    vecs.push_back('{1'b1, 1'b0, 16'h0001, 32'h0,        32'h00000001, 1'b0, "rd_0001"});

    for (int i = 0; i < 3; i++) begin exp_rd[i] = 0; exp_wr[i] = 0; end
    err_clear2 = 1'b0; err_clear0 = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 16'h0, 32'h0);

    // Reset state
    #12;
    check("rst_rdata", b2.ext_mem_rdata, 32'h0);
    check("rst_flags", {b2.ext_mem_ready, busy2, err2}, 3'b000);
    check("rst_counts", {rd_count2, wr_count2}, 32'h0);
    check("rst_w0_flags", {b0.ext_mem_ready, busy0, err0}, 3'b000);
    #10 rst = 1'b1;
    tick();

    // Write latency with two wait states: ready exactly one cycle, busy 3 cycles
    drive(2, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("lat_ready_%0d", k), b2.ext_mem_ready, (k == 2));
      check($sformatf("lat_busy_%0d", k), busy2, (k <= 2));
      if (k == 2) drive(2, 1'b0, 1'b0, 16'h0, 32'h0);
    end
    exp_wr[2] = 1;
    check("lat_wr_count", wr_count2, 16'd1);
    check("lat_rdata", b2.ext_mem_rdata, 32'h0);

    foreach (vecs[i])
      txn(2, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
          vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].name);

    // Out-of-range accesses
    txn(2, 1'b1, 1'b0, 16'h1000, 32'h0, 32'h0, 1'b1, "oor_rd");
    clear_err(2);
    txn(2, 1'b0, 1'b1, 16'h1010, 32'h00000055, 32'h0, 1'b1, "oor_wr");
    clear_err(2);
    txn(2, 1'b1, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, "oor_wr_dropped");

    // err_clear on the same edge as a new error: the set wins
    drive(2, 1'b1, 1'b0, 16'h1000, 32'h0);
    tick();
    tick();
    err_clear2 = 1'b1;
    tick();
    err_clear2 = 1'b0;
    drive(2, 1'b0, 1'b0, 16'h0, 32'h0);
    exp_rd[2]++;
    check("coinc_ready", b2.ext_mem_ready, 1'b1);
    check("coinc_err", err2, 1'b1);
    tick();
    check("coinc_err_hold", err2, 1'b1);
    clear_err(2);

    // Read and write together: treated as a write, flags err
    txn(2, 1'b1, 1'b1, 16'h0020, 32'h12345678, 32'h0, 1'b1, "dual");
    txn(2, 1'b1, 1'b0, 16'h0020, 32'h0, 32'h12345678, 1'b1, "dual_readback");

    // Zero wait states: held read yields two one-cycle pulses
    txn(0, 1'b0, 1'b1, 16'h0008, 32'h600DF00D, 32'h0, 1'b0, "w0_wr");
    drive(0, 1'b1, 1'b0, 16'h0008, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("w0_ready_%0d", k), b0.ext_mem_ready, (k == 0 || k == 2));
      if (k == 0) check("w0_rdata", b0.ext_mem_rdata, 32'h600DF00D);
      if (k == 3) drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    end
    exp_rd[0] += 2;
    check("w0_rd_count", rd_count0, exp_rd[0]);
    check("w0_busy", busy0, 1'b0);

    // Reset in BUSY abandons the write
    drive(2, 1'b0, 1'b1, 16'h0030, 32'h11112222);
    tick();
    check("rstb_busy", busy2, 1'b1);
    drive(2, 1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin exp_rd[i] = 0; exp_wr[i] = 0; end
    check("rstb_flags", {b2.ext_mem_ready, busy2, err2}, 3'b000);
    check("rstb_rdata", b2.ext_mem_rdata, 32'h0);
    check("rstb_counts", {rd_count2, wr_count2}, 32'h0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rstb_no_ready_%0d", k), b2.ext_mem_ready, 1'b0);
    end
    txn(2, 1'b1, 1'b0, 16'h0030, 32'h0, 32'hAAAA5555, 1'b0, "rstb_readback");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
